// File: rtl/spi_regfile_pkg.sv
// Shared types and helpers for the SPI register-file peripheral.
package spi_regfile_pkg;

  typedef logic [2:0] state_t;

  localparam state_t StIdle  = 3'd0;
  localparam state_t StCmd   = 3'd1;
  localparam state_t StWdata = 3'd2;
  localparam state_t StRdata = 3'd3;
  localparam state_t StDone  = 3'd4;

  // Frame width for the default 7-bit address / 8-bit data configuration.
  localparam int unsigned ADDR_W_DEF = 7;
  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned FRAME_W    = 1 + ADDR_W_DEF + DATA_W_DEF;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned p = 1; p < v; p = p << 1) r++;
    return r;
  endfunction

endpackage

// File: rtl/spi_regfile_peripheral_if.sv
// SPI pin bundle: controller drives ncs/sclk/copi, peripheral drives cipo/cipo_oe.
interface spi_regfile_peripheral_if;
  logic ncs;
  logic sclk;
  logic copi;
  logic cipo;
  logic cipo_oe;

  modport master (output ncs, output sclk, output copi, input cipo, input cipo_oe);
  modport slave  (input ncs, input sclk, input copi, output cipo, output cipo_oe);
endinterface

// File: rtl/spi_input_sync.sv
// Multi-flop synchroniser for one asynchronous pin, with a configurable reset value.
module spi_input_sync #(
  parameter int unsigned STAGES    = 2,
  parameter logic        RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q, sync_d;

  always_comb sync_d = {sync_q[STAGES-2:0], d_i};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= {STAGES{RESET_VAL}};
    else        sync_q <= sync_d;
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/spi_regfile_peripheral.sv
// SPI Mode-0 target decoding framed writes/reads into a NUM_REGS x DATA_W register bank.
module spi_regfile_peripheral
  import spi_regfile_pkg::*;
#(
  parameter int unsigned ADDR_W      = 7,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned NUM_REGS    = 5,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  spi_regfile_peripheral_if.slave    spi,
  input  logic                       err_clr,
  output logic [NUM_REGS*DATA_W-1:0] reg_q,
  output logic                       wr_strobe,
  output logic [ADDR_W-1:0]          wr_addr,
  output logic                       frame_err,
  output logic                       addr_err
);

  localparam int unsigned FrameW = 1 + ADDR_W + DATA_W;
  localparam int unsigned CmdW   = 1 + ADDR_W;
  localparam int unsigned SrW    = (CmdW > DATA_W) ? CmdW : DATA_W;
  localparam int unsigned CntW   = clog2(FrameW + 1);

  localparam logic [CntW-1:0] CntCmd       = CntW'(CmdW);
  localparam logic [CntW-1:0] CntCmdLast   = CntW'(CmdW - 1);
  localparam logic [CntW-1:0] CntFrameLast = CntW'(FrameW - 1);

  logic ncs_s, sclk_s, copi_s;

  spi_input_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ncs (
    .clk(clk), .rst_n(rst_n), .d_i(spi.ncs), .q_o(ncs_s)
  );
  spi_input_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rst_n(rst_n), .d_i(spi.sclk), .q_o(sclk_s)
  );
  spi_input_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_copi (
    .clk(clk), .rst_n(rst_n), .d_i(spi.copi), .q_o(copi_s)
  );

  logic ncs_q, sclk_q;
  logic cs_fall, cs_rise, sclk_rise, sclk_fall;

  assign cs_fall   =  ncs_q & ~ncs_s;
  assign cs_rise   = ~ncs_q &  ncs_s;
  assign sclk_rise = ~sclk_q &  sclk_s;
  assign sclk_fall =  sclk_q & ~sclk_s;

  state_t                      state_q, state_d;
  logic [CntW-1:0]             cnt_q, cnt_d;
  logic [SrW-2:0]              sr_q, sr_d;
  logic [SrW-1:0]              sr_shift;
  logic [ADDR_W-1:0]           addr_q, addr_d;
  logic [DATA_W-1:0]           shadow_q, shadow_d;
  logic                        oe_q, oe_d;
  logic [NUM_REGS*DATA_W-1:0]  reg_d;
  logic                        wr_strobe_q, wr_strobe_d;
  logic [ADDR_W-1:0]           wr_addr_q, wr_addr_d;
  logic                        frame_err_q, frame_err_d;
  logic                        addr_err_q, addr_err_d;
  logic                        frame_set, addr_set;
  logic [DATA_W-1:0]           rd_val;

  assign sr_shift = {sr_q, copi_s};

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return 32'(a) < NUM_REGS;
  endfunction

  // Read lookup uses the address as it completes on the last header bit.
  always_comb begin
    rd_val = '0;
    for (int i = 0; i < int'(NUM_REGS); i++) begin
      if (sr_shift[ADDR_W-1:0] == ADDR_W'(i)) rd_val = reg_q[i*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sr_d        = sr_q;
    addr_d      = addr_q;
    shadow_d    = shadow_q;
    oe_d        = oe_q;
    reg_d       = reg_q;
    wr_strobe_d = 1'b0;
    wr_addr_d   = wr_addr_q;
    frame_set   = 1'b0;
    addr_set    = 1'b0;

    if (cs_rise) begin
      state_d   = StIdle;
      oe_d      = 1'b0;
      shadow_d  = '0;
      frame_set = (state_q == StCmd) || (state_q == StWdata) || (state_q == StRdata);
    end else begin
      case (state_q)
        StIdle: begin
          if (cs_fall) begin
            state_d = StCmd;
            cnt_d   = '0;
          end
        end
        StCmd: begin
          if (sclk_rise) begin
            sr_d  = sr_shift[SrW-2:0];
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CntCmdLast) begin
              addr_d = sr_shift[ADDR_W-1:0];
              if (sr_shift[ADDR_W]) begin
                state_d = StWdata;
              end else begin
                state_d  = StRdata;
                oe_d     = 1'b1;
                shadow_d = rd_val;
                addr_set = !in_range(sr_shift[ADDR_W-1:0]);
              end
            end
          end
        end
        StWdata: begin
          if (sclk_rise) begin
            sr_d  = sr_shift[SrW-2:0];
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CntFrameLast) begin
              state_d = StDone;
              if (in_range(addr_q)) begin
                wr_strobe_d = 1'b1;
                wr_addr_d   = addr_q;
                for (int i = 0; i < int'(NUM_REGS); i++) begin
                  if (addr_q == ADDR_W'(i)) reg_d[i*DATA_W +: DATA_W] = sr_shift[DATA_W-1:0];
                end
              end else begin
                addr_set = 1'b1;
              end
            end
          end
        end
        StRdata: begin
          if (sclk_rise) begin
            sr_d  = sr_shift[SrW-2:0];
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CntFrameLast) state_d = StDone;
          end else if (sclk_fall && (cnt_q > CntCmd)) begin
            // The fall before the first data rise must keep the freshly loaded MSB.
            shadow_d = shadow_q << 1;
          end
        end
        StDone: ;
        default: state_d = StIdle;
      endcase
    end

    frame_err_d = frame_set | (frame_err_q & ~err_clr);
    addr_err_d  = addr_set  | (addr_err_q  & ~err_clr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ncs_q       <= 1'b1;
      sclk_q      <= 1'b0;
      state_q     <= StIdle;
      cnt_q       <= '0;
      sr_q        <= '0;
      addr_q      <= '0;
      shadow_q    <= '0;
      oe_q        <= 1'b0;
      reg_q       <= '0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= '0;
      frame_err_q <= 1'b0;
      addr_err_q  <= 1'b0;
    end else begin
      ncs_q       <= ncs_s;
      sclk_q      <= sclk_s;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sr_q        <= sr_d;
      addr_q      <= addr_d;
      shadow_q    <= shadow_d;
      oe_q        <= oe_d;
      reg_q       <= reg_d;
      wr_strobe_q <= wr_strobe_d;
      wr_addr_q   <= wr_addr_d;
      frame_err_q <= frame_err_d;
      addr_err_q  <= addr_err_d;
    end
  end

  assign spi.cipo    = oe_q & shadow_q[DATA_W-1];
  assign spi.cipo_oe = oe_q;
  assign wr_strobe   = wr_strobe_q;
  assign wr_addr     = wr_addr_q;
  assign frame_err   = frame_err_q;
  assign addr_err    = addr_err_q;

endmodule

// File: tb/tb_spi_regfile_peripheral.sv
// Directed bench: frame table on the default 5x8 instance plus hand sequences and a 32x16 sweep.
module tb_spi_regfile_peripheral;

  localparam int Half = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic ncs_a = 1'b1, ncs_b = 1'b1, sclk = 1'b0, copi = 1'b0;
  logic err_clr_a = 1'b0, err_clr_b = 1'b0;

  spi_regfile_peripheral_if if_a ();
  spi_regfile_peripheral_if if_b ();

  assign if_a.ncs  = ncs_a;
  assign if_a.sclk = sclk;
  assign if_a.copi = copi;
  assign if_b.ncs  = ncs_b;
  assign if_b.sclk = sclk;
  assign if_b.copi = copi;

  logic [39:0]  reg_q_a;
  logic [511:0] reg_q_b;
  logic         wr_strobe_a, wr_strobe_b;
  logic [6:0]   wr_addr_a, wr_addr_b;
  logic         frame_err_a, frame_err_b, addr_err_a, addr_err_b;

  spi_regfile_peripheral u_dut_a (
    .clk(clk), .rst_n(rst_n), .spi(if_a.slave), .err_clr(err_clr_a), .reg_q(reg_q_a),
    .wr_strobe(wr_strobe_a), .wr_addr(wr_addr_a), .frame_err(frame_err_a), .addr_err(addr_err_a)
  );

  spi_regfile_peripheral #(.ADDR_W(7), .DATA_W(16), .NUM_REGS(32), .SYNC_STAGES(2)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .spi(if_b.slave), .err_clr(err_clr_b), .reg_q(reg_q_b),
    .wr_strobe(wr_strobe_b), .wr_addr(wr_addr_b), .frame_err(frame_err_b), .addr_err(addr_err_b)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int strobe_cnt_a = 0;
  int strobe_cnt_b = 0;

  always @(negedge clk) begin
    if (wr_strobe_a) strobe_cnt_a <= strobe_cnt_a + 1;
    if (wr_strobe_b) strobe_cnt_b <= strobe_cnt_b + 1;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  logic        oe_seen;
  logic [15:0] rd_word;

  // Drives nbits of a len-bit frame MSB first; bits past len are sent as 1.
  task automatic send_frame(input bit sel, input logic [23:0] frame, input int len,
                            input int nbits, input int hdr, input int dw, input bit raise_cs);
    rd_word = '0;
    oe_seen = 1'b0;
    @(negedge clk);
    if (sel) ncs_b = 1'b0;
    else     ncs_a = 1'b0;
    repeat (Half) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      copi = (i < len) ? frame[len-1-i] : 1'b1;
      repeat (Half) @(negedge clk);
      if (i >= hdr && i < hdr + dw) begin
        rd_word = {rd_word[14:0], (sel ? if_b.cipo : if_a.cipo)};
        if (i == hdr) oe_seen = sel ? if_b.cipo_oe : if_a.cipo_oe;
      end
      sclk = 1'b1;
      repeat (Half) @(negedge clk);
      sclk = 1'b0;
    end
    if (raise_cs) begin
      repeat (Half) @(negedge clk);
      if (sel) ncs_b = 1'b1;
      else     ncs_a = 1'b1;
      repeat (Half) @(negedge clk);
    end
  endtask

  task automatic pulse_clr_a();
    @(negedge clk);
    err_clr_a = 1'b1;
    @(negedge clk);
    err_clr_a = 1'b0;
  endtask

  typedef struct {
    logic [23:0] frame;
    int          len;
    int          nbits;
    bit          clr;
    logic [39:0] exp_reg;
    int          exp_strobes;
    logic [6:0]  exp_wr_addr;
    logic        exp_aerr;
    logic        exp_ferr;
    bit          is_rd;
    logic [7:0]  exp_rd;
  } vec_t;

  vec_t vecs[12];

  initial begin
    int s0;
    logic [15:0] rd_b;

    // Register layout: reg4 [39:32] reg3 [31:24] reg2 [23:16] reg1 [15:8] reg0 [7:0].
    vecs[0]  = '{24'h0082A5, 16, 16, 0, 40'h00_00_A5_00_00, 1, 7'd2, 0, 0, 0, 8'h00};
    vecs[1]  = '{24'h00843C, 16, 16, 0, 40'h3C_00_A5_00_00, 1, 7'd4, 0, 0, 0, 8'h00};
    vecs[2]  = '{24'h0004FF, 16, 16, 0, 40'h3C_00_A5_00_00, 0, 7'd4, 0, 0, 1, 8'h3C};
    vecs[3]  = '{24'h0083C3, 16, 16, 0, 40'h3C_C3_A5_00_00, 1, 7'd3, 0, 0, 0, 8'h00};
    vecs[4]  = '{24'h000300, 16, 16, 0, 40'h3C_C3_A5_00_00, 0, 7'd3, 0, 0, 1, 8'hC3};
    vecs[5]  = '{24'h008955, 16, 16, 0, 40'h3C_C3_A5_00_00, 0, 7'd3, 1, 0, 0, 8'h00};
    vecs[6]  = '{24'h000900, 16, 16, 0, 40'h3C_C3_A5_00_00, 0, 7'd3, 1, 0, 1, 8'h00};
    vecs[7]  = '{24'h00807E, 16, 16, 1, 40'h3C_C3_A5_00_7E, 1, 7'd0, 0, 0, 0, 8'h00};
    vecs[8]  = '{24'h008133, 16, 10, 0, 40'h3C_C3_A5_00_7E, 0, 7'd0, 0, 1, 0, 8'h00};
    vecs[9]  = '{24'h8011FF, 24, 24, 1, 40'h3C_C3_A5_00_11, 1, 7'd0, 0, 0, 0, 8'h00};
    vecs[10] = '{24'h000000, 16, 16, 0, 40'h3C_C3_A5_00_11, 0, 7'd0, 0, 0, 1, 8'h11};
    vecs[11] = '{24'h000100, 16, 16, 0, 40'h3C_C3_A5_00_11, 0, 7'd0, 0, 0, 1, 8'h00};

    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    check("rst reg_q_a", 64'(reg_q_a), 64'h0);
    check("rst reg_q_b nonzero", 64'(|reg_q_b), 64'h0);
    check("rst wr_strobe", 64'(wr_strobe_a), 64'h0);
    check("rst wr_addr", 64'(wr_addr_a), 64'h0);
    check("rst frame_err", 64'(frame_err_a), 64'h0);
    check("rst addr_err", 64'(addr_err_a), 64'h0);
    check("rst cipo", 64'(if_a.cipo), 64'h0);
    check("rst cipo_oe", 64'(if_a.cipo_oe), 64'h0);

    for (int i = 0; i < 12; i++) begin
      if (vecs[i].clr) pulse_clr_a();
      s0 = strobe_cnt_a;
      send_frame(1'b0, vecs[i].frame, vecs[i].len, vecs[i].nbits, 8, 8, 1'b1);
      check($sformatf("v%0d reg_q", i), 64'(reg_q_a), 64'(vecs[i].exp_reg));
      check($sformatf("v%0d strobe cycles", i), 64'(strobe_cnt_a - s0),
            64'(vecs[i].exp_strobes));
      check($sformatf("v%0d wr_addr", i), 64'(wr_addr_a), 64'(vecs[i].exp_wr_addr));
      check($sformatf("v%0d addr_err", i), 64'(addr_err_a), 64'(vecs[i].exp_aerr));
      check($sformatf("v%0d frame_err", i), 64'(frame_err_a), 64'(vecs[i].exp_ferr));
      check($sformatf("v%0d cipo_oe after cs", i), 64'(if_a.cipo_oe), 64'h0);
      if (vecs[i].is_rd) begin
        check($sformatf("v%0d read data", i), 64'(rd_word[7:0]), 64'(vecs[i].exp_rd));
        check($sformatf("v%0d cipo_oe during read", i), 64'(oe_seen), 64'h1);
      end
    end

    // Set both flags, then reset in the middle of a write frame.
    send_frame(1'b0, 24'h008100, 16, 5, 8, 8, 1'b1);
    send_frame(1'b0, 24'h008A00, 16, 16, 8, 8, 1'b1);
    check("pre-rst frame_err", 64'(frame_err_a), 64'h1);
    check("pre-rst addr_err", 64'(addr_err_a), 64'h1);
    send_frame(1'b0, 24'h008322, 16, 12, 8, 8, 1'b0);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("midrst reg_q", 64'(reg_q_a), 64'h0);
    check("midrst frame_err", 64'(frame_err_a), 64'h0);
    check("midrst addr_err", 64'(addr_err_a), 64'h0);
    check("midrst wr_addr", 64'(wr_addr_a), 64'h0);
    check("midrst cipo_oe", 64'(if_a.cipo_oe), 64'h0);
    ncs_a = 1'b1;
    sclk  = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (Half) @(negedge clk);
    s0 = strobe_cnt_a;
    send_frame(1'b0, 24'h008199, 16, 16, 8, 8, 1'b1);
    check("postrst reg_q", 64'(reg_q_a), 64'h00_00_00_99_00);
    check("postrst strobe cycles", 64'(strobe_cnt_a - s0), 64'h1);
    check("postrst wr_addr", 64'(wr_addr_a), 64'h1);

    // 16-bit data, 32 registers.
    s0 = strobe_cnt_b;
    send_frame(1'b1, 24'h9FBEEF, 24, 24, 8, 16, 1'b1);
    check("b reg31", 64'(reg_q_b[511:496]), 64'hBEEF);
    check("b other regs nonzero", 64'(|reg_q_b[495:0]), 64'h0);
    check("b strobe cycles", 64'(strobe_cnt_b - s0), 64'h1);
    check("b wr_addr", 64'(wr_addr_b), 64'd31);
    check("b addr_err", 64'(addr_err_b), 64'h0);
    send_frame(1'b1, 24'h1F0000, 24, 24, 8, 16, 1'b1);
    rd_b = rd_word;
    check("b read reg31", 64'(rd_b), 64'hBEEF);
    check("b cipo_oe during read", 64'(oe_seen), 64'h1);
    send_frame(1'b1, 24'h280000, 24, 24, 8, 16, 1'b1);
    check("b read addr40", 64'(rd_word), 64'h0);
    check("b addr_err addr40", 64'(addr_err_b), 64'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
